// File: rtl/flt_cmd_pkg.sv
// flt_cmd_pkg: opcodes, response codes and FSM states for the flight command processor
package flt_cmd_pkg;

    typedef enum logic [7:0] {
        SET_PTCH  = 8'h02,
        SET_ROLL  = 8'h03,
        SET_YAW   = 8'h04,
        SET_THRST = 8'h05,
        CALIBRATE = 8'h06,
        EMER_LAND = 8'h07,
        MTRS_OFF  = 8'h08
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        RESP,
        ESC_WAIT,
        CAL,
        CAL_RESP
    } state_t;

    localparam logic [7:0] ACK     = 8'hA5;
    localparam logic [7:0] NAK     = 8'hEE;
    localparam int         THRST_W = 9;

endpackage

// File: rtl/flt_cmd_proc_esc_wait_tmr.sv
// esc_wait_tmr: clear/enable up-counter with an all-ones terminal-count flag
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clr_i     zero the counter (wins over en_i)
//   en_i      count up by one
//   tc_o      counter is all-ones
module esc_wait_tmr #(
    parameter int W = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i)
            cnt_q <= '0;
        else if (en_i)
            cnt_q <= cnt_q + W'(1);
    end

    assign tc_o = &cnt_q;

endmodule

// File: rtl/flt_cmd_proc.sv
// flt_cmd_proc: host command decoder holding flight setpoints and sequencing ESC wake-up and calibration
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   cmd_rdy_i         a complete host packet is waiting
//   cmd_i, data_i     packet opcode and payload
//   clr_cmd_rdy_o     one-cycle pulse, packet consumed
//   resp_o            response byte, send_resp_o pulses to transmit it
//   cal_done_i        inertial calibration finished
//   strt_cal_o        one-cycle pulse, start inertial calibration
//   inertial_cal_o    high from ESC wait through calibration
//   motors_off_o      forces ESC outputs to minimum
//   d_ptch_o, d_roll_o, d_yaw_o, thrst_o  setpoints
// Build option: FLT_CMD_FAST_SIM_EN shortens the ESC wait to 512 cycles.
module flt_cmd_proc
    import flt_cmd_pkg::*;
#(
    parameter int WAIT_BITS = 26
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_rdy_i,
    input  logic [7:0]         cmd_i,
    input  logic [15:0]        data_i,
    output logic               clr_cmd_rdy_o,
    output logic [7:0]         resp_o,
    output logic               send_resp_o,
    input  logic               cal_done_i,
    output logic               strt_cal_o,
    output logic               inertial_cal_o,
    output logic               motors_off_o,
    output logic [15:0]        d_ptch_o,
    output logic [15:0]        d_roll_o,
    output logic [15:0]        d_yaw_o,
    output logic [THRST_W-1:0] thrst_o
);

`ifdef FLT_CMD_FAST_SIM_EN
    localparam int TW = 9;
`else
    localparam int TW = WAIT_BITS;
`endif

    state_t             state_q, state_d;
    logic [15:0]        ptch_q, ptch_d, roll_q, roll_d, yaw_q, yaw_d;
    logic [THRST_W-1:0] thrst_q, thrst_d;
    logic               moff_q, moff_d, ical_q, ical_d;
    logic               clr_q, clr_d, send_q, send_d, strt_q, strt_d;
    logic [7:0]         resp_q, resp_d;
    logic               tmr_clr, tmr_tc;

    esc_wait_tmr #(.W(TW)) u_tmr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (tmr_clr),
        .en_i  (state_q == ESC_WAIT),
        .tc_o  (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptch_q  <= '0;
            roll_q  <= '0;
            yaw_q   <= '0;
            thrst_q <= '0;
            moff_q  <= 1'b1;
            ical_q  <= 1'b0;
            clr_q   <= 1'b0;
            send_q  <= 1'b0;
            strt_q  <= 1'b0;
            resp_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            ptch_q  <= ptch_d;
            roll_q  <= roll_d;
            yaw_q   <= yaw_d;
            thrst_q <= thrst_d;
            moff_q  <= moff_d;
            ical_q  <= ical_d;
            clr_q   <= clr_d;
            send_q  <= send_d;
            strt_q  <= strt_d;
            resp_q  <= resp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptch_d  = ptch_q;
        roll_d  = roll_q;
        yaw_d   = yaw_q;
        thrst_d = thrst_q;
        moff_d  = moff_q;
        ical_d  = ical_q;
        resp_d  = resp_q;
        clr_d   = 1'b0;
        send_d  = 1'b0;
        strt_d  = 1'b0;
        tmr_clr = 1'b0;
        case (state_q)
            IDLE: if (cmd_rdy_i) begin
                clr_d = 1'b1;
                if (cmd_i == CALIBRATE) begin
                    moff_d  = 1'b0;
                    ical_d  = 1'b1;
                    tmr_clr = 1'b1;
                    state_d = ESC_WAIT;
                end else begin
                    send_d  = 1'b1;
                    resp_d  = ACK;
                    state_d = RESP;
                    case (cmd_i)
                        SET_PTCH:  ptch_d  = data_i;
                        SET_ROLL:  roll_d  = data_i;
                        SET_YAW:   yaw_d   = data_i;
                        SET_THRST: thrst_d = data_i[THRST_W-1:0];
                        EMER_LAND: begin
                            ptch_d  = '0;
                            roll_d  = '0;
                            yaw_d   = '0;
                            thrst_d = '0;
                        end
                        MTRS_OFF:  moff_d  = 1'b1;
                        default:   resp_d  = NAK;
                    endcase
                end
            end
            RESP, CAL_RESP: state_d = IDLE;
            ESC_WAIT: if (tmr_tc) begin
                strt_d  = 1'b1;
                state_d = CAL;
            end
            CAL: if (cal_done_i) begin
                ical_d  = 1'b0;
                send_d  = 1'b1;
                resp_d  = ACK;
                state_d = CAL_RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    assign clr_cmd_rdy_o  = clr_q;
    assign send_resp_o    = send_q;
    assign strt_cal_o     = strt_q;
    assign resp_o         = resp_q;
    assign inertial_cal_o = ical_q;
    assign motors_off_o   = moff_q;
    assign d_ptch_o       = ptch_q;
    assign d_roll_o       = roll_q;
    assign d_yaw_o        = yaw_q;
    assign thrst_o        = thrst_q;

endmodule

// File: tb/tb_flt_cmd_proc.sv
// tb_flt_cmd_proc: directed self-checking bench for flt_cmd_proc with a 512-cycle ESC wait
module tb_flt_cmd_proc;

    logic        clk = 1'b0;
    logic        rst, cmd_rdy, cal_done;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy, send_resp, strt_cal, inertial_cal, motors_off;
    logic [7:0]  resp;
    logic [15:0] d_ptch, d_roll, d_yaw;
    logic [8:0]  thrst;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cnt;
    logic        seen;

    always #5 clk = ~clk;

    flt_cmd_proc #(.WAIT_BITS(9)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_rdy_i      (cmd_rdy),
        .cmd_i          (cmd),
        .data_i         (data),
        .clr_cmd_rdy_o  (clr_cmd_rdy),
        .resp_o         (resp),
        .send_resp_o    (send_resp),
        .cal_done_i     (cal_done),
        .strt_cal_o     (strt_cal),
        .inertial_cal_o (inertial_cal),
        .motors_off_o   (motors_off),
        .d_ptch_o       (d_ptch),
        .d_roll_o       (d_roll),
        .d_yaw_o        (d_yaw),
        .thrst_o        (thrst)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // cmd_rdy is held through the RESP cycle to show it is ignored there
    task automatic send(input logic [7:0] c, input logic [15:0] d, input logic [7:0] r);
        cmd = c;
        data = d;
        cmd_rdy = 1'b1;
        @(posedge clk) #1;
        check("clr_pulse", clr_cmd_rdy, 1);
        check("send_pulse", send_resp, 1);
        check("resp", resp, r);
        @(posedge clk) #1;
        check("clr_single", clr_cmd_rdy, 0);
        check("send_single", send_resp, 0);
        cmd_rdy = 1'b0;
    endtask

    task automatic start_cal();
        cmd = 8'h06;
        data = 16'h0000;
        cmd_rdy = 1'b1;
        @(posedge clk) #1;
        check("cal_clr", clr_cmd_rdy, 1);
        check("cal_no_send", send_resp, 0);
        check("cal_moff", motors_off, 0);
        check("cal_ical", inertial_cal, 1);
        cmd_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cmd_rdy = 1'b0;
        cal_done = 1'b0;
        cmd = 8'h00;
        data = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ptch", d_ptch, 0);
        check("rst_roll", d_roll, 0);
        check("rst_yaw", d_yaw, 0);
        check("rst_thrst", thrst, 0);
        check("rst_moff", motors_off, 1);
        check("rst_clr", clr_cmd_rdy, 0);
        check("rst_send", send_resp, 0);
        check("rst_strt", strt_cal, 0);
        check("rst_ical", inertial_cal, 0);
        check("rst_resp", resp, 8'h00);
        rst = 1'b0;

        send(8'h05, 16'h00FF, 8'hA5);
        check("thrst_ff", thrst, 9'h0FF);
        send(8'h02, 16'h0100, 8'hA5);
        send(8'h03, 16'hFF80, 8'hA5);
        send(8'h04, 16'h0080, 8'hA5);
        check("ptch_256", d_ptch, 16'h0100);
        check("roll_m128", d_roll, 16'hFF80);
        check("yaw_128", d_yaw, 16'h0080);

        send(8'h3C, 16'h1234, 8'hEE);
        check("nak_ptch", d_ptch, 16'h0100);
        check("nak_roll", d_roll, 16'hFF80);
        check("nak_yaw", d_yaw, 16'h0080);
        check("nak_thrst", thrst, 9'h0FF);
        check("nak_moff", motors_off, 1);

        start_cal();
        cnt = 0;
        seen = 1'b0;
        while (!strt_cal && cnt < 1000) begin
            @(posedge clk) #1;
            cnt++;
            if (cnt == 100) begin
                cmd = 8'h04;
                data = 16'h1234;
                cmd_rdy = 1'b1;
            end
            seen = seen | clr_cmd_rdy | send_resp;
        end
        check("esc_wait_len", cnt, 512);
        check("strt_cal", strt_cal, 1);
        @(posedge clk) #1;
        check("strt_single", strt_cal, 0);
        check("ical_in_cal", inertial_cal, 1);
        repeat (99) begin
            @(posedge clk) #1;
            seen = seen | clr_cmd_rdy | send_resp;
        end
        check("no_consume_wait", seen, 0);
        cal_done = 1'b1;
        @(posedge clk) #1;
        cal_done = 1'b0;
        check("cal_ack_send", send_resp, 1);
        check("cal_ack_resp", resp, 8'hA5);
        check("cal_ical_low", inertial_cal, 0);
        check("cal_ack_noclr", clr_cmd_rdy, 0);
        @(posedge clk) #1;
        check("cal_resp_send", send_resp, 0);
        check("cal_resp_clr", clr_cmd_rdy, 0);
        @(posedge clk) #1;
        check("late_yaw_clr", clr_cmd_rdy, 1);
        check("late_yaw_send", send_resp, 1);
        check("late_yaw_val", d_yaw, 16'h1234);
        cmd_rdy = 1'b0;
        @(posedge clk) #1;
        check("late_yaw_single", send_resp, 0);

        cal_done = 1'b1;
        @(posedge clk) #1;
        cal_done = 1'b0;
        @(posedge clk) #1;
        check("idle_cal_done", send_resp, 0);

        send(8'h07, 16'hFFFF, 8'hA5);
        check("el_ptch", d_ptch, 0);
        check("el_roll", d_roll, 0);
        check("el_yaw", d_yaw, 0);
        check("el_thrst", thrst, 0);
        check("el_moff", motors_off, 0);
        send(8'h08, 16'h0000, 8'hA5);
        check("moff_set", motors_off, 1);
        send(8'h05, 16'hFE37, 8'hA5);
        check("thrst_trunc", thrst, 9'h037);

        start_cal();
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        check("mrst_send", send_resp, 0);
        check("mrst_moff", motors_off, 1);
        check("mrst_ical", inertial_cal, 0);
        check("mrst_thrst", thrst, 0);
        seen = 1'b0;
        repeat (600) begin
            @(posedge clk) #1;
            seen = seen | send_resp | strt_cal;
        end
        check("mrst_quiet", seen, 0);
        send(8'h02, 16'h7FFF, 8'hA5);
        check("mrst_idle_ptch", d_ptch, 16'h7FFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
